bram_heap_ctrl: RTL and testbench

Min-heap priority-queue controller that drives both ports of the team's dual-port BRAM (`dual_port_bram`). It turns enqueue, dequeue and replace requests into sift-up and sift-down sequences of BRAM reads and writes. It sits directly upstream of the BRAM in the BRAM_tree design and replaces the free-running test counters that currently drive the BRAM address and data ports. The root (minimum) is cached in a register, so a peek costs no latency.

---
 rtl/bram_heap_ctrl_if.sv | 40 ++++
 rtl/bram_heap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bram_heap_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_heap_ctrl_if.sv
// rtl/bram_heap_ctrl_if.sv - request, status and dual-port BRAM signals of the heap controller
interface bram_heap_ctrl_if #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  i_enq_valid;
  logic [KEY_WIDTH-1:0]  i_enq_data;
  logic                  i_deq_req;
  logic                  o_ready;
  logic                  o_deq_valid;
  logic [KEY_WIDTH-1:0]  o_deq_data;
  logic [KEY_WIDTH-1:0]  o_min;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_bram_ena_a;
  logic                  o_bram_we_a;
  logic [ADDR_WIDTH-1:0] o_bram_addr_a;
  logic [KEY_WIDTH-1:0]  o_bram_din_a;
  logic [KEY_WIDTH-1:0]  i_bram_dout_a;
  logic                  o_bram_ena_b;
  logic                  o_bram_we_b;
  logic [ADDR_WIDTH-1:0] o_bram_addr_b;
  logic [KEY_WIDTH-1:0]  o_bram_din_b;
  logic [KEY_WIDTH-1:0]  i_bram_dout_b;

  modport slave (
    input  i_enq_valid, i_enq_data, i_deq_req, i_bram_dout_a, i_bram_dout_b,
    output o_ready, o_deq_valid, o_deq_data, o_min, o_count, o_empty, o_full,
    output o_bram_ena_a, o_bram_we_a, o_bram_addr_a, o_bram_din_a,
    output o_bram_ena_b, o_bram_we_b, o_bram_addr_b, o_bram_din_b
  );

  modport master (
    output i_enq_valid, i_enq_data, i_deq_req, i_bram_dout_a, i_bram_dout_b,
    input  o_ready, o_deq_valid, o_deq_data, o_min, o_count, o_empty, o_full,
    input  o_bram_ena_a, o_bram_we_a, o_bram_addr_a, o_bram_din_a,
    input  o_bram_ena_b, o_bram_we_b, o_bram_addr_b, o_bram_din_b
  );
endinterface

// File: rtl/bram_heap_ctrl.sv
// rtl/bram_heap_ctrl.sv - min-heap priority queue driving both ports of a dual-port BRAM
module bram_heap_ctrl #(
  parameter int KEY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic              CLK,
  input logic              RSTn,
  bram_heap_ctrl_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, UP_RD, UP_CMP, DN_LAST, DN_WAIT, DN_RD, DN_CMP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [CW-1:0]        hole, hole_n;
  logic [KEY_WIDTH-1:0] key, key_n;
  logic [KEY_WIDTH-1:0] min_q;
  logic [KEY_WIDTH-1:0] deq_data, deq_data_n;
  logic                 deq_valid, deq_valid_n;

  logic                  ena_a, we_a, ena_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [KEY_WIDTH-1:0]  din_a;

  logic [CW-1:0]        l_idx, r_idx, parent;
  logic                 r_ok, use_r, empty, full;
  logic [KEY_WIDTH-1:0] child;

  assign empty  = (count == '0);
  assign full   = (count == CAP);
  assign parent = (hole - CW'(1)) >> 1;
  assign l_idx  = (hole << 1) + CW'(1);
  assign r_idx  = l_idx + CW'(1);
  assign r_ok   = (r_idx < count);
  assign use_r  = r_ok && (bus.i_bram_dout_b < bus.i_bram_dout_a);
  assign child  = use_r ? bus.i_bram_dout_b : bus.i_bram_dout_a;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      count     <= '0;
      hole      <= '0;
      key       <= '0;
      min_q     <= '0;
      deq_data  <= '0;
      deq_valid <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      hole      <= hole_n;
      key       <= key_n;
      deq_data  <= deq_data_n;
      deq_valid <= deq_valid_n;
      // The root is mirrored in a register so peeking never touches the BRAM.
      if (we_a && addr_a == '0)
        min_q <= din_a;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    hole_n      = hole;
    key_n       = key;
    deq_data_n  = deq_data;
    deq_valid_n = 1'b0;
    ena_a       = 1'b0;
    we_a        = 1'b0;
    addr_a      = '0;
    din_a       = '0;
    ena_b       = 1'b0;
    addr_b      = '0;
    unique case (state)
      IDLE: begin
        if (bus.i_enq_valid && bus.i_deq_req && !empty) begin
          deq_valid_n = 1'b1;
          deq_data_n  = min_q;
          key_n       = bus.i_enq_data;
          hole_n      = '0;
          state_n     = DN_RD;
        end else if (bus.i_enq_valid && !full) begin
          key_n   = bus.i_enq_data;
          hole_n  = count;
          count_n = count + CW'(1);
          state_n = UP_RD;
        end else if (bus.i_deq_req && !bus.i_enq_valid && !empty) begin
          deq_valid_n = 1'b1;
          deq_data_n  = min_q;
          count_n     = count - CW'(1);
          state_n     = (count == CW'(1)) ? IDLE : DN_LAST;
        end
      end
      UP_RD: begin
        ena_a = 1'b1;
        if (hole == '0) begin
          we_a    = 1'b1;
          din_a   = key;
          state_n = IDLE;
        end else begin
          addr_a  = parent[ADDR_WIDTH-1:0];
          state_n = UP_CMP;
        end
      end
      UP_CMP: begin
        ena_a  = 1'b1;
        we_a   = 1'b1;
        addr_a = hole[ADDR_WIDTH-1:0];
        if (key < bus.i_bram_dout_a) begin
          din_a   = bus.i_bram_dout_a;
          hole_n  = parent;
          state_n = UP_RD;
        end else begin
          din_a   = key;
          state_n = IDLE;
        end
      end
      DN_LAST: begin
        // count already points past the new last slot, i.e. at the old last entry
        ena_a   = 1'b1;
        addr_a  = count[ADDR_WIDTH-1:0];
        state_n = DN_WAIT;
      end
      DN_WAIT: begin
        key_n   = bus.i_bram_dout_a;
        hole_n  = '0;
        state_n = DN_RD;
      end
      DN_RD: begin
        ena_a = 1'b1;
        if (l_idx >= count) begin
          we_a    = 1'b1;
          addr_a  = hole[ADDR_WIDTH-1:0];
          din_a   = key;
          state_n = IDLE;
        end else begin
          addr_a  = l_idx[ADDR_WIDTH-1:0];
          ena_b   = r_ok;
          addr_b  = r_ok ? r_idx[ADDR_WIDTH-1:0] : '0;
          state_n = DN_CMP;
        end
      end
      DN_CMP: begin
        ena_a  = 1'b1;
        we_a   = 1'b1;
        addr_a = hole[ADDR_WIDTH-1:0];
        if (child < key) begin
          din_a   = child;
          hole_n  = use_r ? r_idx : l_idx;
          state_n = DN_RD;
        end else begin
          din_a   = key;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_ready       = (state == IDLE);
  assign bus.o_deq_valid   = deq_valid;
  assign bus.o_deq_data    = deq_data;
  assign bus.o_min         = min_q;
  assign bus.o_count       = count;
  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_bram_ena_a  = ena_a & RSTn;
  assign bus.o_bram_we_a   = we_a & RSTn;
  assign bus.o_bram_addr_a = addr_a;
  assign bus.o_bram_din_a  = din_a;
  assign bus.o_bram_ena_b  = ena_b & RSTn;
  assign bus.o_bram_we_b   = 1'b0;
  assign bus.o_bram_addr_b = addr_b;
  assign bus.o_bram_din_b  = '0;
endmodule

// File: tb/tb_bram_heap_ctrl.sv
// tb/tb_bram_heap_ctrl.sv - scoreboard bench for bram_heap_ctrl with a behavioural dual-port BRAM
module tb_bram_heap_ctrl;
  localparam int KW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_heap_ctrl_if #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW)) bus();
  bram_heap_ctrl #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW)) dut (.CLK(clk), .RSTn(rstn), .bus(bus));

  logic [KW-1:0] mem [CAP];
  always @(posedge clk) begin
    if (bus.o_bram_ena_a) begin
      if (bus.o_bram_we_a) mem[bus.o_bram_addr_a] <= bus.o_bram_din_a;
      bus.i_bram_dout_a <= mem[bus.o_bram_addr_a];
    end
    if (bus.o_bram_ena_b) begin
      if (bus.o_bram_we_b) mem[bus.o_bram_addr_b] <= bus.o_bram_din_b;
      bus.i_bram_dout_b <= mem[bus.o_bram_addr_b];
    end
  end

  int total = 0;
  int bad   = 0;
  logic [KW-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_deq_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_deq: got %0d expected no pulse", bus.o_deq_data);
      end else begin
        logic [KW-1:0] e;
        e = sb.pop_front();
        if (bus.o_deq_data !== e) begin
          bad++;
          $display("FAIL deq_data: got %0d expected %0d", bus.o_deq_data, e);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
  endtask

  task automatic enq(input logic [KW-1:0] k);
    wait_ready();
    bus.i_enq_valid = 1'b1; bus.i_enq_data = k;
    @(posedge clk); #1;
    bus.i_enq_valid = 1'b0;
  endtask

  task automatic deq(input logic [KW-1:0] exp);
    wait_ready();
    sb.push_back(exp);
    bus.i_deq_req = 1'b1;
    @(posedge clk); #1;
    bus.i_deq_req = 1'b0;
  endtask

  task automatic chk_mem4(input string name, input logic [KW-1:0] a, b, c, d);
    chk({name, "_0"}, mem[0], a);
    chk({name, "_1"}, mem[1], b);
    chk({name, "_2"}, mem[2], c);
    chk({name, "_3"}, mem[3], d);
  endtask

  int keys [$];

  initial begin
    bus.i_enq_valid = 1'b0; bus.i_enq_data = '0; bus.i_deq_req = 1'b0;
    bus.i_enq_valid = 1'b1; bus.i_deq_req = 1'b1; bus.i_enq_data = 8'd99;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", bus.o_count, 0);
    chk("rst_empty", bus.o_empty, 1);
    chk("rst_full", bus.o_full, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_min", bus.o_min, 0);
    chk("rst_deq_data", bus.o_deq_data, 0);
    chk("rst_deq_valid", bus.o_deq_valid, 0);
    chk("rst_ena", {bus.o_bram_ena_a, bus.o_bram_we_a, bus.o_bram_ena_b, bus.o_bram_we_b}, 0);
    bus.i_enq_valid = 1'b0; bus.i_deq_req = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // single enqueue: write at T+1, status and ready at T+2
    enq(8'd5);
    chk("t1_we", {bus.o_bram_ena_a, bus.o_bram_we_a}, 2'b11);
    chk("t1_addr", bus.o_bram_addr_a, 0);
    chk("t1_din", bus.o_bram_din_a, 5);
    chk("t1_count_t1", bus.o_count, 1);
    @(posedge clk); #1;
    chk("t1_min", bus.o_min, 5);
    chk("t1_ready", bus.o_ready, 1);
    deq(8'd5);
    chk("t1_deq_pulse", bus.o_deq_valid, 1);
    chk("t1_empty", bus.o_empty, 1);

    // sift-up order
    enq(8'd40); enq(8'd30); enq(8'd20); enq(8'd10);
    wait_ready();
    chk_mem4("t2_mem", 8'd10, 8'd20, 8'd30, 8'd40);
    chk("t2_min", bus.o_min, 10);
    chk("t2_count", bus.o_count, 4);

    // sorted drain
    deq(8'd10); deq(8'd20); deq(8'd30); deq(8'd40);
    wait_ready();
    chk("t3_empty", bus.o_empty, 1);
    chk("t3_count", bus.o_count, 0);

    // replace
    enq(8'd40); enq(8'd30); enq(8'd20); enq(8'd10);
    wait_ready();
    sb.push_back(8'd10);
    bus.i_enq_valid = 1'b1; bus.i_deq_req = 1'b1; bus.i_enq_data = 8'd25;
    @(posedge clk); #1;
    bus.i_enq_valid = 1'b0; bus.i_deq_req = 1'b0;
    wait_ready();
    chk_mem4("t5_mem", 8'd20, 8'd25, 8'd30, 8'd40);
    chk("t5_count", bus.o_count, 4);
    chk("t5_min", bus.o_min, 20);
    deq(8'd20); deq(8'd25); deq(8'd30); deq(8'd40);
    wait_ready();

    // full capacity
    for (int i = 0; i < CAP; i++) begin
      int k;
      k = $urandom_range(0, 255);
      keys.push_back(k);
      enq(k[KW-1:0]);
    end
    wait_ready();
    chk("t4_full", bus.o_full, 1);
    chk("t4_count", bus.o_count, CAP);
    bus.i_enq_valid = 1'b1; bus.i_enq_data = 8'd0;
    @(posedge clk); #1;
    bus.i_enq_valid = 1'b0;
    chk("t4_extra_ena", bus.o_bram_ena_a, 0);
    chk("t4_extra_count", bus.o_count, CAP);
    chk("t4_extra_ready", bus.o_ready, 1);
    keys.sort();
    for (int i = 0; i < CAP; i++) deq(keys[i][KW-1:0]);
    wait_ready();
    chk("t4_empty", bus.o_empty, 1);

    // edge requests on empty
    bus.i_deq_req = 1'b1;
    @(posedge clk); #1;
    bus.i_deq_req = 1'b0;
    chk("t6_deq_empty_valid", bus.o_deq_valid, 0);
    chk("t6_deq_empty_ena", bus.o_bram_ena_a, 0);
    bus.i_enq_valid = 1'b1; bus.i_deq_req = 1'b1; bus.i_enq_data = 8'd7;
    @(posedge clk); #1;
    bus.i_enq_valid = 1'b0; bus.i_deq_req = 1'b0;
    chk("t6_both_valid", bus.o_deq_valid, 0);
    chk("t6_both_count", bus.o_count, 1);
    chk("t6_both_din", bus.o_bram_din_a, 7);
    wait_ready();
    chk("t6_both_min", bus.o_min, 7);

    // reset in the middle of a sift-down
    for (int i = 1; i <= 7; i++) enq(8'(i * 10));
    wait_ready();
    deq(8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_in_dn_rd", bus.o_bram_ena_a, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_count", bus.o_count, 0);
    chk("t6_rst_ready", bus.o_ready, 1);
    chk("t6_rst_ena", {bus.o_bram_ena_a, bus.o_bram_ena_b}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("t6_post_ena", {bus.o_bram_ena_a, bus.o_bram_ena_b}, 0);
    chk("t6_post_empty", bus.o_empty, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
